// File: rtl/instruction_decode_stage_pkg.sv
// Shared MIPS ID-stage definitions: opcode/funct encodings, ALU operation set,
// and the IF/ID and ID/EX pipeline register layouts.
package instruction_decode_stage_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0a;
    localparam logic [5:0] OP_SLTIU  = 6'h0b;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_XORI   = 6'h0e;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } AluOp;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        valid;
    } IF_ID_Register;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_value;
        logic [31:0] rt_value;
        logic [31:0] imm_ext;
        logic [31:0] link_addr;
        logic [4:0]  shamt;
        logic [4:0]  dest;
        AluOp        alu_op;
        logic        alu_src_imm;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic        link;
        logic        valid;
    } ID_EX_Register;

    function automatic AluOp funct_alu(input logic [5:0] funct);
        case (funct)
            FN_SUBU: return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_XOR:  return ALU_XOR;
            FN_NOR:  return ALU_NOR;
            FN_SLT:  return ALU_SLT;
            FN_SLTU: return ALU_SLTU;
            FN_SLL:  return ALU_SLL;
            FN_SRL:  return ALU_SRL;
            FN_SRA:  return ALU_SRA;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic AluOp opcode_alu(input logic [5:0] opcode);
        case (opcode)
            OP_SLTI:  return ALU_SLT;
            OP_SLTIU: return ALU_SLTU;
            OP_ANDI:  return ALU_AND;
            OP_ORI:   return ALU_OR;
            OP_XORI:  return ALU_XOR;
            OP_LUI:   return ALU_LUI;
            default:  return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/instruction_decode_stage_hazard_unit.sv
// Combinational stall detection for the ID stage: load-use hazards and
// branch/jr operands that are not yet forwardable.
module instruction_decode_stage_hazard_unit (
    input  logic       uses_rs_i,
    input  logic       uses_rt_i,
    input  logic       ctrl_dep_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic       id_ex_valid_i,
    input  logic       id_ex_mem_read_i,
    input  logic       id_ex_reg_write_i,
    input  logic [4:0] id_ex_dest_i,
    input  logic       ex_mem_mem_read_i,
    input  logic       ex_mem_reg_write_i,
    input  logic [4:0] ex_mem_dest_i,
    output logic       stall_o
);

    logic rs_live, rt_live;
    logic hit_id_ex, hit_ex_mem;
    logic load_use, id_ex_dep, ex_mem_dep;

    // $0 is hardwired, so a source of $0 can never depend on anything.
    assign rs_live = uses_rs_i && (rs_i != 5'd0);
    assign rt_live = uses_rt_i && (rt_i != 5'd0);

    assign hit_id_ex  = (rs_live && (rs_i == id_ex_dest_i)) ||
                        (rt_live && (rt_i == id_ex_dest_i));
    assign hit_ex_mem = (rs_live && (rs_i == ex_mem_dest_i)) ||
                        (rt_live && (rt_i == ex_mem_dest_i));

    assign load_use   = id_ex_valid_i && id_ex_mem_read_i && hit_id_ex;
    assign id_ex_dep  = ctrl_dep_i && id_ex_valid_i && id_ex_reg_write_i && hit_id_ex;
    assign ex_mem_dep = ctrl_dep_i && ex_mem_mem_read_i && ex_mem_reg_write_i && hit_ex_mem;

    assign stall_o = load_use || id_ex_dep || ex_mem_dep;

endmodule

// File: rtl/instruction_decode_stage.sv
// MIPS ID stage: decode, operand forwarding, branch/jump resolution, hazard
// stalls and the registered ID/EX pipeline register.
module instruction_decode_stage
    import instruction_decode_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic          clk,
    input  logic          rst,
    input  IF_ID_Register if_id_reg,
    output logic [4:0]    rf_rs_addr,
    output logic [4:0]    rf_rt_addr,
    input  logic [31:0]   rf_rs_data,
    input  logic [31:0]   rf_rt_data,
    input  logic          ex_mem_reg_write,
    input  logic          ex_mem_mem_read,
    input  logic [4:0]    ex_mem_dest,
    input  logic [31:0]   ex_mem_value,
    input  logic          mem_wb_reg_write,
    input  logic [4:0]    mem_wb_dest,
    input  logic [31:0]   mem_wb_value,
    output logic          stall,
    output logic          flush,
    output logic          jump_enable,
    output logic [31:0]   jump_address,
    output ID_EX_Register id_ex_reg
);

    logic [31:0] instr, pc_plus4, br_target, j_target, target;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] rs_fwd, rt_fwd;
    logic signed [31:0] rs_s;
    logic uses_rs, uses_rt, ctrl_dep, is_jump, br_taken;
    logic hz_stall, stall_int, redirect;
    ID_EX_Register id_ex_d, id_ex_q, reset_val;

    assign instr  = if_id_reg.instruction;
    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];

    assign rf_rs_addr = rs;
    assign rf_rt_addr = rt;

    assign pc_plus4  = if_id_reg.pc + 32'd4;
    assign br_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};

    // EX/MEM loads are excluded: their data does not exist until MEM completes.
    function automatic logic [31:0] fwd_operand(
        input logic [4:0]  addr,
        input logic [31:0] rf_val,
        input logic        exm_wr,
        input logic        exm_ld,
        input logic [4:0]  exm_dst,
        input logic [31:0] exm_val,
        input logic        mwb_wr,
        input logic [4:0]  mwb_dst,
        input logic [31:0] mwb_val
    );
        if (addr == 5'd0)                             return 32'd0;
        else if (exm_wr && !exm_ld && exm_dst == addr) return exm_val;
        else if (mwb_wr && mwb_dst == addr)            return mwb_val;
        else                                           return rf_val;
    endfunction

    assign rs_fwd = fwd_operand(rs, rf_rs_data, ex_mem_reg_write, ex_mem_mem_read, ex_mem_dest,
                                ex_mem_value, mem_wb_reg_write, mem_wb_dest, mem_wb_value);
    assign rt_fwd = fwd_operand(rt, rf_rt_data, ex_mem_reg_write, ex_mem_mem_read, ex_mem_dest,
                                ex_mem_value, mem_wb_reg_write, mem_wb_dest, mem_wb_value);
    assign rs_s   = rs_fwd;

    always_comb begin
        id_ex_d           = '0;
        id_ex_d.pc        = if_id_reg.pc;
        id_ex_d.rs_value  = rs_fwd;
        id_ex_d.rt_value  = rt_fwd;
        id_ex_d.shamt     = shamt;
        id_ex_d.link_addr = pc_plus4;
        id_ex_d.valid     = if_id_reg.valid;
        id_ex_d.imm_ext   = {{16{imm[15]}}, imm};
        uses_rs  = 1'b0;
        uses_rt  = 1'b0;
        ctrl_dep = 1'b0;
        is_jump  = 1'b0;
        br_taken = 1'b0;
        target   = br_target;

        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                        uses_rs           = 1'b1;
                        uses_rt           = 1'b1;
                        id_ex_d.dest      = rd;
                        id_ex_d.reg_write = 1'b1;
                        id_ex_d.alu_op    = funct_alu(funct);
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        uses_rt           = 1'b1;
                        id_ex_d.dest      = rd;
                        id_ex_d.reg_write = 1'b1;
                        id_ex_d.alu_op    = funct_alu(funct);
                    end
                    FN_JR: begin
                        uses_rs  = 1'b1;
                        ctrl_dep = 1'b1;
                        is_jump  = 1'b1;
                        target   = rs_fwd;
                    end
                    FN_JALR: begin
                        uses_rs           = 1'b1;
                        ctrl_dep          = 1'b1;
                        is_jump           = 1'b1;
                        target            = rs_fwd;
                        id_ex_d.dest      = rd;
                        id_ex_d.reg_write = 1'b1;
                        id_ex_d.link      = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                uses_rs             = 1'b1;
                id_ex_d.dest        = rt;
                id_ex_d.reg_write   = 1'b1;
                id_ex_d.alu_src_imm = 1'b1;
                id_ex_d.alu_op      = opcode_alu(opcode);
            end
            OP_LUI: begin
                id_ex_d.dest        = rt;
                id_ex_d.reg_write   = 1'b1;
                id_ex_d.alu_src_imm = 1'b1;
                id_ex_d.alu_op      = ALU_LUI;
            end
            OP_LW: begin
                uses_rs             = 1'b1;
                id_ex_d.dest        = rt;
                id_ex_d.reg_write   = 1'b1;
                id_ex_d.mem_read    = 1'b1;
                id_ex_d.mem_to_reg  = 1'b1;
                id_ex_d.alu_src_imm = 1'b1;
            end
            OP_SW: begin
                uses_rs             = 1'b1;
                uses_rt             = 1'b1;
                id_ex_d.mem_write   = 1'b1;
                id_ex_d.alu_src_imm = 1'b1;
            end
            OP_BEQ: begin
                uses_rs  = 1'b1;
                uses_rt  = 1'b1;
                ctrl_dep = 1'b1;
                br_taken = (rs_fwd == rt_fwd);
            end
            OP_BNE: begin
                uses_rs  = 1'b1;
                uses_rt  = 1'b1;
                ctrl_dep = 1'b1;
                br_taken = (rs_fwd != rt_fwd);
            end
            OP_BLEZ: begin
                uses_rs  = 1'b1;
                ctrl_dep = 1'b1;
                br_taken = (rs_s <= 0);
            end
            OP_BGTZ: begin
                uses_rs  = 1'b1;
                ctrl_dep = 1'b1;
                br_taken = (rs_s > 0);
            end
            OP_REGIMM: begin
                if (rt == RT_BLTZ || rt == RT_BGEZ) begin
                    uses_rs  = 1'b1;
                    ctrl_dep = 1'b1;
                    br_taken = (rt == RT_BLTZ) ? (rs_s < 0) : (rs_s >= 0);
                end
            end
            OP_J: begin
                is_jump = 1'b1;
                target  = j_target;
            end
            OP_JAL: begin
                is_jump           = 1'b1;
                target            = j_target;
                id_ex_d.dest      = 5'd31;
                id_ex_d.reg_write = 1'b1;
                id_ex_d.link      = 1'b1;
            end
            default: ;
        endcase

        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: id_ex_d.imm_ext = {16'd0, imm};
            OP_LUI:                   id_ex_d.imm_ext = {imm, 16'd0};
            default: ;
        endcase

        // Writes to $0 are dropped, which also makes the all-zero word a true nop.
        if (id_ex_d.dest == 5'd0) id_ex_d.reg_write = 1'b0;

        if (!if_id_reg.valid) begin
            id_ex_d.reg_write  = 1'b0;
            id_ex_d.mem_read   = 1'b0;
            id_ex_d.mem_write  = 1'b0;
            id_ex_d.mem_to_reg = 1'b0;
            id_ex_d.link       = 1'b0;
            uses_rs            = 1'b0;
            uses_rt            = 1'b0;
            ctrl_dep           = 1'b0;
            is_jump            = 1'b0;
            br_taken           = 1'b0;
        end
    end

    instruction_decode_stage_hazard_unit u_hazard (
        .uses_rs_i          (uses_rs),
        .uses_rt_i          (uses_rt),
        .ctrl_dep_i         (ctrl_dep),
        .rs_i               (rs),
        .rt_i               (rt),
        .id_ex_valid_i      (id_ex_q.valid),
        .id_ex_mem_read_i   (id_ex_q.mem_read),
        .id_ex_reg_write_i  (id_ex_q.reg_write),
        .id_ex_dest_i       (id_ex_q.dest),
        .ex_mem_mem_read_i  (ex_mem_mem_read),
        .ex_mem_reg_write_i (ex_mem_reg_write),
        .ex_mem_dest_i      (ex_mem_dest),
        .stall_o            (hz_stall)
    );

    assign stall_int    = !rst && hz_stall;
    assign redirect     = !rst && !stall_int && (br_taken || is_jump);
    assign stall        = stall_int;
    assign flush        = redirect;
    assign jump_enable  = redirect;
    assign jump_address = redirect ? target : 32'd0;

    always_comb begin
        reset_val    = '0;
        reset_val.pc = RESET_PC;
    end

    always_ff @(posedge clk) begin
        if (rst)            id_ex_q <= reset_val;
        else if (stall_int) id_ex_q <= '0;
        else                id_ex_q <= id_ex_d;
    end

    assign id_ex_reg = id_ex_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for instruction_decode_stage: each task drives a scenario and
// compares outputs against hand-computed values.
module tb_instruction_decode_stage;
    import instruction_decode_stage_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    IF_ID_Register if_id;
    logic [4:0]    rf_rs_addr, rf_rt_addr;
    logic [31:0]   rf_rs_data, rf_rt_data;
    logic          ex_mem_reg_write, ex_mem_mem_read;
    logic [4:0]    ex_mem_dest;
    logic [31:0]   ex_mem_value;
    logic          mem_wb_reg_write;
    logic [4:0]    mem_wb_dest;
    logic [31:0]   mem_wb_value;
    logic          stall, flush, jump_enable;
    logic [31:0]   jump_address;
    ID_EX_Register id_ex;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_decode_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_id_reg        (if_id),
        .rf_rs_addr       (rf_rs_addr),
        .rf_rt_addr       (rf_rt_addr),
        .rf_rs_data       (rf_rs_data),
        .rf_rt_data       (rf_rt_data),
        .ex_mem_reg_write (ex_mem_reg_write),
        .ex_mem_mem_read  (ex_mem_mem_read),
        .ex_mem_dest      (ex_mem_dest),
        .ex_mem_value     (ex_mem_value),
        .mem_wb_reg_write (mem_wb_reg_write),
        .mem_wb_dest      (mem_wb_dest),
        .mem_wb_value     (mem_wb_value),
        .stall            (stall),
        .flush            (flush),
        .jump_enable      (jump_enable),
        .jump_address     (jump_address),
        .id_ex_reg        (id_ex)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_if(input logic [31:0] pc, input logic [31:0] instr);
        if_id.pc          = pc;
        if_id.instruction = instr;
        if_id.valid       = 1'b1;
    endtask

    task automatic clear_fwd();
        ex_mem_reg_write = 1'b0;
        ex_mem_mem_read  = 1'b0;
        ex_mem_dest      = 5'd0;
        ex_mem_value     = 32'd0;
        mem_wb_reg_write = 1'b0;
        mem_wb_dest      = 5'd0;
        mem_wb_value     = 32'd0;
    endtask

    task automatic idle();
        if_id.valid       = 1'b0;
        if_id.instruction = 32'd0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_if(32'h0000_3004, 32'h0C00_0C10);
        tick();
        tick();
        checks++; if (id_ex.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", id_ex.valid); end
        checks++; if (id_ex.pc !== 32'h3000) begin errors++; $display("FAIL reset_pc got=%h exp=00003000", id_ex.pc); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        checks++; if (jump_enable !== 1'b0) begin errors++; $display("FAIL reset_jump_enable got=%0b exp=0", jump_enable); end
        checks++; if (jump_address !== 32'd0) begin errors++; $display("FAIL reset_jump_address got=%h exp=0", jump_address); end
    endtask

    task automatic test_addiu();
        rst = 1'b0;
        set_if(32'h0000_3000, 32'h2401_0005);
        tick();
        checks++; if (id_ex.imm_ext !== 32'd5) begin errors++; $display("FAIL addiu_imm got=%h exp=5", id_ex.imm_ext); end
        checks++; if (id_ex.dest !== 5'd1) begin errors++; $display("FAIL addiu_dest got=%0d exp=1", id_ex.dest); end
        checks++; if (id_ex.reg_write !== 1'b1 || id_ex.valid !== 1'b1 || id_ex.alu_src_imm !== 1'b1)
            begin errors++; $display("FAIL addiu_ctrl got rw=%0b v=%0b imm=%0b exp=1,1,1", id_ex.reg_write, id_ex.valid, id_ex.alu_src_imm); end
    endtask

    task automatic test_load_use();
        idle();
        set_if(32'h0000_3008, 32'h8C22_0000);
        tick();
        set_if(32'h0000_300C, 32'h0042_1821);
        #1;
        checks++; if (stall !== 1'b1 || jump_enable !== 1'b0 || flush !== 1'b0)
            begin errors++; $display("FAIL load_use_stall got s=%0b j=%0b f=%0b exp=1,0,0", stall, jump_enable, flush); end
        tick();
        checks++; if (id_ex.valid !== 1'b0 || id_ex.reg_write !== 1'b0 || id_ex.mem_read !== 1'b0)
            begin errors++; $display("FAIL load_use_bubble got v=%0b rw=%0b mr=%0b exp=0,0,0", id_ex.valid, id_ex.reg_write, id_ex.mem_read); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_use_one_cycle got=%0b exp=0", stall); end
        tick();
        checks++; if (id_ex.valid !== 1'b1 || id_ex.dest !== 5'd3 || id_ex.reg_write !== 1'b1)
            begin errors++; $display("FAIL load_use_issue got v=%0b d=%0d rw=%0b exp=1,3,1", id_ex.valid, id_ex.dest, id_ex.reg_write); end
    endtask

    task automatic test_reset_mid_stall();
        set_if(32'h0000_3008, 32'h8C22_0000);
        tick();
        set_if(32'h0000_300C, 32'h0042_1821);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL midrst_pre_stall got=%0b exp=1", stall); end
        rst = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall_drop got=%0b exp=0", stall); end
        tick();
        checks++; if (id_ex.valid !== 1'b0 || id_ex.pc !== 32'h3000)
            begin errors++; $display("FAIL midrst_clear got v=%0b pc=%h exp=0,00003000", id_ex.valid, id_ex.pc); end
        rst = 1'b0;
    endtask

    task automatic test_branch();
        idle();
        rf_rs_data = 32'd7;
        rf_rt_data = 32'd7;
        set_if(32'h0000_3010, 32'h1021_0003);
        #1;
        checks++; if (rf_rs_addr !== 5'd1 || rf_rt_addr !== 5'd1)
            begin errors++; $display("FAIL beq_rf_addr got=%0d,%0d exp=1,1", rf_rs_addr, rf_rt_addr); end
        checks++; if (jump_enable !== 1'b1 || flush !== 1'b1 || stall !== 1'b0)
            begin errors++; $display("FAIL beq_taken got j=%0b f=%0b s=%0b exp=1,1,0", jump_enable, flush, stall); end
        checks++; if (jump_address !== 32'h3020) begin errors++; $display("FAIL beq_target got=%h exp=00003020", jump_address); end
        set_if(32'h0000_3010, 32'h1421_0003);
        #1;
        checks++; if (jump_enable !== 1'b0 || flush !== 1'b0)
            begin errors++; $display("FAIL bne_not_taken got j=%0b f=%0b exp=0,0", jump_enable, flush); end
        rf_rs_data = 32'h8000_0000;
        set_if(32'h0000_3000, 32'h0420_0004);
        #1;
        checks++; if (jump_enable !== 1'b1 || jump_address !== 32'h3014)
            begin errors++; $display("FAIL bltz_neg got j=%0b a=%h exp=1,00003014", jump_enable, jump_address); end
        rf_rs_data = 32'd0;
        set_if(32'h0000_3000, 32'h1C20_0004);
        #1;
        checks++; if (jump_enable !== 1'b0) begin errors++; $display("FAIL bgtz_zero got=%0b exp=0", jump_enable); end
    endtask

    task automatic test_branch_dep();
        idle();
        set_if(32'h0000_303C, 32'h0022_2021);
        tick();
        set_if(32'h0000_3040, 32'h1080_0002);
        #1;
        checks++; if (stall !== 1'b1 || jump_enable !== 1'b0)
            begin errors++; $display("FAIL brdep_stall got s=%0b j=%0b exp=1,0", stall, jump_enable); end
        tick();
        ex_mem_reg_write = 1'b1;
        ex_mem_dest      = 5'd4;
        ex_mem_value     = 32'd0;
        rf_rs_data       = 32'h55;
        rf_rt_data       = 32'd0;
        #1;
        checks++; if (id_ex.valid !== 1'b0) begin errors++; $display("FAIL brdep_bubble got=%0b exp=0", id_ex.valid); end
        checks++; if (stall !== 1'b0 || jump_enable !== 1'b1 || jump_address !== 32'h304C)
            begin errors++; $display("FAIL brdep_fwd_taken got s=%0b j=%0b a=%h exp=0,1,0000304c", stall, jump_enable, jump_address); end
        ex_mem_mem_read = 1'b1;
        #1;
        checks++; if (stall !== 1'b1 || jump_enable !== 1'b0)
            begin errors++; $display("FAIL brdep_exmem_load got s=%0b j=%0b exp=1,0", stall, jump_enable); end
        clear_fwd();
    endtask

    task automatic test_jal();
        idle();
        set_if(32'h0000_3004, 32'h0C00_0C10);
        #1;
        checks++; if (jump_enable !== 1'b1 || flush !== 1'b1 || jump_address !== 32'h3040)
            begin errors++; $display("FAIL jal_redirect got j=%0b f=%0b a=%h exp=1,1,00003040", jump_enable, flush, jump_address); end
        tick();
        checks++; if (id_ex.dest !== 5'd31 || id_ex.link !== 1'b1 || id_ex.reg_write !== 1'b1)
            begin errors++; $display("FAIL jal_link got d=%0d l=%0b rw=%0b exp=31,1,1", id_ex.dest, id_ex.link, id_ex.reg_write); end
        checks++; if (id_ex.link_addr !== 32'h3008) begin errors++; $display("FAIL jal_link_addr got=%h exp=00003008", id_ex.link_addr); end
    endtask

    task automatic test_jr_and_zero();
        idle();
        mem_wb_reg_write = 1'b1;
        mem_wb_dest      = 5'd31;
        mem_wb_value     = 32'h3100;
        rf_rs_data       = 32'hDEAD;
        set_if(32'h0000_3020, 32'h03E0_0008);
        #1;
        checks++; if (stall !== 1'b0 || jump_enable !== 1'b1 || jump_address !== 32'h3100)
            begin errors++; $display("FAIL jr_fwd got s=%0b j=%0b a=%h exp=0,1,00003100", stall, jump_enable, jump_address); end
        clear_fwd();
        ex_mem_reg_write = 1'b1;
        ex_mem_mem_read  = 1'b1;
        ex_mem_dest      = 5'd0;
        rf_rs_data       = 32'h1234;
        rf_rt_data       = 32'h1234;
        set_if(32'h0000_3050, 32'h1000_0001);
        #1;
        checks++; if (stall !== 1'b0 || jump_enable !== 1'b1 || jump_address !== 32'h3058)
            begin errors++; $display("FAIL zero_src got s=%0b j=%0b a=%h exp=0,1,00003058", stall, jump_enable, jump_address); end
        tick();
        checks++; if (id_ex.rs_value !== 32'd0 || id_ex.rt_value !== 32'd0)
            begin errors++; $display("FAIL zero_operand got=%h,%h exp=0,0", id_ex.rs_value, id_ex.rt_value); end
        clear_fwd();
    endtask

    task automatic test_immediates();
        idle();
        set_if(32'h0000_3060, 32'h3401_8000);
        tick();
        checks++; if (id_ex.imm_ext !== 32'h0000_8000) begin errors++; $display("FAIL ori_zext got=%h exp=00008000", id_ex.imm_ext); end
        set_if(32'h0000_3064, 32'h3C01_1234);
        tick();
        checks++; if (id_ex.imm_ext !== 32'h1234_0000 || id_ex.alu_op !== ALU_LUI)
            begin errors++; $display("FAIL lui_imm got=%h op=%0d exp=12340000,%0d", id_ex.imm_ext, id_ex.alu_op, ALU_LUI); end
        set_if(32'h0000_3068, 32'h2401_FFFF);
        tick();
        checks++; if (id_ex.imm_ext !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addiu_sext got=%h exp=ffffffff", id_ex.imm_ext); end
        set_if(32'h0000_306C, 32'hFC00_0000);
        tick();
        checks++; if (id_ex.valid !== 1'b1 || id_ex.reg_write !== 1'b0 || id_ex.mem_read !== 1'b0 || id_ex.mem_write !== 1'b0)
            begin errors++; $display("FAIL unknown_nop got v=%0b rw=%0b mr=%0b mw=%0b exp=1,0,0,0", id_ex.valid, id_ex.reg_write, id_ex.mem_read, id_ex.mem_write); end
        set_if(32'h0000_3070, 32'h0000_0000);
        tick();
        checks++; if (id_ex.valid !== 1'b1 || id_ex.reg_write !== 1'b0 || id_ex.mem_write !== 1'b0)
            begin errors++; $display("FAIL zero_word_nop got v=%0b rw=%0b mw=%0b exp=1,0,0", id_ex.valid, id_ex.reg_write, id_ex.mem_write); end
    endtask

    initial begin
        rst = 1'b1;
        if_id = '0;
        rf_rs_data = 32'd0;
        rf_rt_data = 32'd0;
        clear_fwd();
        test_reset();
        test_addiu();
        test_load_use();
        test_reset_mid_stall();
        test_branch();
        test_branch_dep();
        test_jal();
        test_jr_and_zero();
        test_immediates();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
